// File: rtl/uarc_send_scheduler.sv
// uarc_send_scheduler
//   Arbitrates remote send requests from TOTAL_BUSES receiver buses and
//   offers one at a time to the core. Two modes:
//     * interrupt mode (i_wait_req=0): requests are masked by a per-bus
//       enable table. An accepted offer starts an interrupt handler at the
//       configured address and blocks further offers until i_irq_done.
//     * wait mode (i_wait_req=1): requests are masked by i_wait_mask. An
//       accepted offer is a plain receive completion with address 0.
//   Selection is round-robin, starting from the bus after the last acked one.
//
// Ports
//   i_clk, i_reset             clock, async active-low reset
//   i_receiver_sends/datas     per-bus request and payload (flat, bus i at [i*WORD_WIDTH +: WORD_WIDTH])
//   o_receiver_send_acks       per-bus one-cycle acknowledge
//   i_cfg_we/bus/enable/addr   enable/handler-address table write port
//   i_wait_req, i_wait_mask    wait-mode select and bus mask
//   o_sel_valid/i_sel_ready    offer handshake to the core
//   o_sel_bus/addr/data/is_irq offered bus, handler address, payload, kind
//   i_irq_done, o_irq_active   handler return / handler in progress
module uarc_send_scheduler #(
  parameter  int WORD_MAG           = 5,
  parameter  int TOTAL_BUSES        = 4,
  parameter  int PROGRAM_ADDR_WIDTH = 8,
  localparam int WORD_WIDTH         = 1 << WORD_MAG,
  localparam int PTR_W              = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic [TOTAL_BUSES-1:0]              i_receiver_sends,
  input  logic [TOTAL_BUSES*WORD_WIDTH-1:0]   i_receiver_datas,
  output logic [TOTAL_BUSES-1:0]              o_receiver_send_acks,
  input  logic                                i_cfg_we,
  input  logic [WORD_WIDTH-1:0]               i_cfg_bus,
  input  logic                                i_cfg_enable,
  input  logic [PROGRAM_ADDR_WIDTH-1:0]       i_cfg_addr,
  input  logic                                i_wait_req,
  input  logic [TOTAL_BUSES-1:0]              i_wait_mask,
  output logic                                o_sel_valid,
  input  logic                                i_sel_ready,
  output logic [WORD_WIDTH-1:0]               o_sel_bus,
  output logic [PROGRAM_ADDR_WIDTH-1:0]       o_sel_addr,
  output logic [WORD_WIDTH-1:0]               o_sel_data,
  output logic                                o_sel_is_irq,
  input  logic                                i_irq_done,
  output logic                                o_irq_active
);

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_ACK, S_BUSY} state_t;

  state_t                                     r_state;
  logic [PTR_W-1:0]                           r_rr_ptr;
  logic [PTR_W-1:0]                           r_bus;
  logic [PROGRAM_ADDR_WIDTH-1:0]              r_addr;
  logic [WORD_WIDTH-1:0]                      r_data;
  logic                                       r_irq;
  logic                                       r_sel_valid;
  logic                                       r_irq_active;
  logic [TOTAL_BUSES-1:0]                     r_acks;
  logic [TOTAL_BUSES-1:0]                     r_en;
  logic [TOTAL_BUSES-1:0][PROGRAM_ADDR_WIDTH-1:0] r_addr_tbl;

  logic [TOTAL_BUSES-1:0]                     w_masked;
  logic                                       w_found;
  logic [PTR_W-1:0]                           w_win;
  logic [PTR_W-1:0]                           w_rr_next;
  int                                         w_idx;

  assign w_masked = i_receiver_sends & (i_wait_req ? i_wait_mask : r_en);

  // Round-robin: scan upward from r_rr_ptr, wrapping, first hit wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < TOTAL_BUSES; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= TOTAL_BUSES) w_idx = w_idx - TOTAL_BUSES;
      if (!w_found && w_masked[w_idx]) begin
        w_found = 1'b1;
        w_win   = PTR_W'(w_idx);
      end
    end
  end

  // With one bus this is always 0, so the pointer never moves.
  assign w_rr_next = (r_bus == PTR_W'(TOTAL_BUSES - 1)) ? '0 : r_bus + PTR_W'(1);

  // Config table. Out-of-range bus indices match no entry and are dropped.
  // The FSM reads the registered table, so a same-cycle write is not seen
  // by arbitration until the following edge.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_en       <= '0;
      r_addr_tbl <= '0;
    end else if (i_cfg_we) begin
      for (int i = 0; i < TOTAL_BUSES; i++) begin
        if (i_cfg_bus == WORD_WIDTH'(i)) begin
          r_en[i]       <= i_cfg_enable;
          r_addr_tbl[i] <= i_cfg_addr;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_bus        <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_irq        <= 1'b0;
      r_sel_valid  <= 1'b0;
      r_irq_active <= 1'b0;
      r_acks       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state     <= S_OFFER;
            r_sel_valid <= 1'b1;
            r_bus       <= w_win;
            r_addr      <= i_wait_req ? '0 : r_addr_tbl[w_win];
            r_data      <= i_receiver_datas[int'(w_win)*WORD_WIDTH +: WORD_WIDTH];
            r_irq       <= ~i_wait_req;
          end
        end
        S_OFFER: begin
          // Accept takes priority over the sender dropping its request.
          if (i_sel_ready) begin
            r_state     <= S_ACK;
            r_sel_valid <= 1'b0;
            r_rr_ptr    <= w_rr_next;
            for (int i = 0; i < TOTAL_BUSES; i++)
              r_acks[i] <= (r_bus == PTR_W'(i));
          end else if (!i_receiver_sends[r_bus]) begin
            r_state     <= S_IDLE;
            r_sel_valid <= 1'b0;
          end
        end
        S_ACK: begin
          r_acks <= '0;
          if (r_irq) begin
            r_state      <= S_BUSY;
            r_irq_active <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (i_irq_done) begin
            r_state      <= S_IDLE;
            r_irq_active <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_receiver_send_acks = r_acks;
  assign o_sel_valid          = r_sel_valid;
  assign o_sel_bus            = WORD_WIDTH'(r_bus);
  assign o_sel_addr           = r_addr;
  assign o_sel_data           = r_data;
  assign o_sel_is_irq         = r_irq;
  assign o_irq_active         = r_irq_active;

endmodule

// File: tb/tb_uarc_send_scheduler.sv
module tb_uarc_send_scheduler;
  localparam int NB = 4;
  localparam int WW = 32;
  localparam int AW = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NB-1:0]     sends = '0;
  logic [NB*WW-1:0]  datas = '0;
  logic [NB-1:0]     acks;
  logic              cfg_we = 1'b0;
  logic [WW-1:0]     cfg_bus = '0;
  logic              cfg_en = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic              wait_req = 1'b0;
  logic [NB-1:0]     wait_mask = '0;
  logic              sel_valid;
  logic              sel_ready = 1'b0;
  logic [WW-1:0]     sel_bus;
  logic [AW-1:0]     sel_addr;
  logic [WW-1:0]     sel_data;
  logic              sel_is_irq;
  logic              irq_done = 1'b0;
  logic              irq_active;

  uarc_send_scheduler dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_receiver_sends(sends), .i_receiver_datas(datas),
    .o_receiver_send_acks(acks),
    .i_cfg_we(cfg_we), .i_cfg_bus(cfg_bus), .i_cfg_enable(cfg_en), .i_cfg_addr(cfg_addr),
    .i_wait_req(wait_req), .i_wait_mask(wait_mask),
    .o_sel_valid(sel_valid), .i_sel_ready(sel_ready),
    .o_sel_bus(sel_bus), .o_sel_addr(sel_addr), .o_sel_data(sel_data),
    .o_sel_is_irq(sel_is_irq), .i_irq_done(irq_done), .o_irq_active(irq_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] bus;
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    logic          irq;
  } offer_t;

  offer_t        exp_off[$];
  logic [NB-1:0] exp_ack[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int bus, input logic en, input logic [AW-1:0] addr);
    cfg_we = 1'b1; cfg_bus = WW'(bus); cfg_en = en; cfg_addr = addr;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic set_data(input int bus, input logic [WW-1:0] v);
    datas[bus*WW +: WW] = v;
  endtask

  task automatic push(input int bus, input logic [AW-1:0] addr, input logic [WW-1:0] data,
                      input logic irq, input logic do_ack);
    offer_t o;
    o.bus = WW'(bus); o.addr = addr; o.data = data; o.irq = irq;
    exp_off.push_back(o);
    if (do_ack) exp_ack.push_back(NB'(1) << bus);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick();
  endtask

  // Accept the current offer and finish the handler (interrupt mode).
  task automatic accept_irq();
    sel_ready = 1'b1; tick();
    sends = '0; sel_ready = 1'b0; tick();
    irq_done = 1'b1; tick();
    irq_done = 1'b0;
  endtask

  // Monitor: compares each new offer and each ack pulse against the queues.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (sel_valid && !prev_valid) begin
      if (exp_off.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_offer: got bus %0d, expected no offer", sel_bus);
      end else begin
        offer_t e;
        e = exp_off.pop_front();
        chk("offer_bus", sel_bus, e.bus);
        chk("offer_addr", 32'(sel_addr), 32'(e.addr));
        chk("offer_data", sel_data, e.data);
        chk("offer_irq", 32'(sel_is_irq), 32'(e.irq));
      end
    end
    if (acks != '0) begin
      if (exp_ack.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_ack: got 0x%0h, expected no ack", acks);
      end else begin
        logic [NB-1:0] a;
        a = exp_ack.pop_front();
        chk("ack", 32'(acks), 32'(a));
      end
    end
    prev_valid = sel_valid;
  end

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sel_valid", 32'(sel_valid), 0);
    chk("rst_is_irq", 32'(sel_is_irq), 0);
    chk("rst_irq_active", 32'(irq_active), 0);
    chk("rst_acks", 32'(acks), 0);
    chk("rst_sel_bus", sel_bus, 0);
    chk("rst_sel_addr", 32'(sel_addr), 0);
    chk("rst_sel_data", sel_data, 0);
    tick(2);
    rst_n = 1'b1;
    tick();

    // Single interrupt on bus 2
    cfg(2, 1'b1, 8'h40);
    set_data(2, 32'hDEADBEEF);
    push(2, 8'h40, 32'hDEADBEEF, 1'b1, 1'b1);
    sends = 4'b0100;
    tick();
    chk("t1_latency_valid", 32'(sel_valid), 1);
    sel_ready = 1'b1; tick();
    chk("t1_ack_pulse", 32'(acks), 32'h4);
    sends = '0; sel_ready = 1'b0; tick();
    chk("t1_ack_cleared", 32'(acks), 0);
    chk("t1_irq_active", 32'(irq_active), 1);
    tick(3);
    chk("t1_irq_held", 32'(irq_active), 1);
    irq_done = 1'b1; tick();
    irq_done = 1'b0;
    chk("t1_irq_released", 32'(irq_active), 0);

    // Round-robin order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NB; i++) begin
      cfg(i, 1'b1, AW'(8'h10 + i));
      set_data(i, 32'h1000_0000 + i);
    end
    for (int k = 0; k < 5; k++)
      push(k % NB, AW'(8'h10 + (k % NB)), 32'h1000_0000 + (k % NB), 1'b1, 1'b1);
    sends = 4'b1111; sel_ready = 1'b1; irq_done = 1'b1;
    tick(19);
    sends = '0; sel_ready = 1'b0;
    tick(2);
    irq_done = 1'b0;
    chk("t2_offers_drained", exp_off.size(), 0);
    chk("t2_acks_drained", exp_ack.size(), 0);

    // Out-of-range config write, then wait-mode completion on bus 3
    do_reset();
    cfg(4, 1'b1, 8'h77);
    sends = 4'b0001;
    tick(2);
    chk("t3_cfg_oob_ignored", 32'(sel_valid), 0);
    set_data(0, 32'h0BAD_0000);
    set_data(3, 32'h12345678);
    wait_req = 1'b1; wait_mask = 4'b1000; sends = 4'b1001;
    push(3, 8'h00, 32'h12345678, 1'b0, 1'b1);
    tick();
    sel_ready = 1'b1; tick();
    sends = '0; sel_ready = 1'b0; tick();
    chk("t3_no_irq_active", 32'(irq_active), 0);
    chk("t3_idle_no_valid", 32'(sel_valid), 0);
    wait_req = 1'b0; wait_mask = '0;

    // Withdraw keeps rr_ptr; config write during offer keeps latched addr
    cfg(0, 1'b1, 8'h20);
    cfg(1, 1'b1, 8'h21);
    set_data(0, 32'hA0);
    push(0, 8'h20, 32'hA0, 1'b1, 1'b1);
    sends = 4'b0001; tick();
    accept_irq();
    set_data(1, 32'hB1);
    push(1, 8'h21, 32'hB1, 1'b1, 1'b0);
    sends = 4'b0010; tick();
    chk("t4_offer_up", 32'(sel_valid), 1);
    sends = '0; tick();
    chk("t4_withdrawn", 32'(sel_valid), 0);
    tick();
    chk("t4_no_ack", 32'(acks), 0);
    set_data(0, 32'hC0);
    set_data(1, 32'hC1);
    push(1, 8'h21, 32'hC1, 1'b1, 1'b1);
    sends = 4'b0011; tick();
    cfg(1, 1'b1, 8'h99);
    chk("t4_latched_addr", 32'(sel_addr), 32'h21);
    chk("t4_still_offered", 32'(sel_valid), 1);
    accept_irq();

    // No offer while BUSY; next offer one cycle after return to IDLE
    set_data(0, 32'hD0);
    push(0, 8'h20, 32'hD0, 1'b1, 1'b1);
    sends = 4'b0001; tick();
    sel_ready = 1'b1; tick();
    sel_ready = 1'b0;
    set_data(1, 32'hD1);
    sends = 4'b0010; tick();
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_nesting", 32'(sel_valid), 0);
      tick();
    end
    push(1, 8'h99, 32'hD1, 1'b1, 1'b1);
    irq_done = 1'b1; tick();
    irq_done = 1'b0;
    chk("t5_idle_no_valid", 32'(sel_valid), 0);
    tick();
    chk("t5_offer_after_idle", 32'(sel_valid), 1);
    accept_irq();

    // Same-cycle enable and arbitration uses the old table
    set_data(2, 32'hE2);
    sends = 4'b0100;
    cfg(2, 1'b1, 8'h42);
    chk("t6_pre_write_table", 32'(sel_valid), 0);
    push(2, 8'h42, 32'hE2, 1'b1, 1'b1);
    tick();
    chk("t6_offer_next", 32'(sel_valid), 1);
    accept_irq();

    // Reset during ACK
    set_data(2, 32'hF2);
    push(2, 8'h42, 32'hF2, 1'b1, 1'b1);
    sends = 4'b0100; tick();
    sel_ready = 1'b1; tick();
    sel_ready = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t7_rst_acks", 32'(acks), 0);
    chk("t7_rst_valid", 32'(sel_valid), 0);
    chk("t7_rst_irq_active", 32'(irq_active), 0);
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t7_table_cleared", 32'(sel_valid), 0);
      chk("t7_no_busy", 32'(irq_active), 0);
    end
    sends = '0;
    tick(2);

    chk("offer_queue_empty", exp_off.size(), 0);
    chk("ack_queue_empty", exp_ack.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not reach the end, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/uarc_send_scheduler.md
UARC_SEND_SCHEDULER -- requirements
Module: uarc_send_scheduler

Interface
REQ-001 Parameter WORD_MAG, default 5, log2 of word width; WORD_WIDTH = 1 << WORD_MAG.
REQ-002 Parameter TOTAL_BUSES, default 4, number of receiver buses arbitrated; range 1 to 2^WORD_WIDTH.
REQ-003 Parameter PROGRAM_ADDR_WIDTH, default 8, width of interrupt handler addresses.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 receiver_sends  in  TOTAL_BUSES  per-bus send request from remote senders.
REQ-007 receiver_datas  in  TOTAL_BUSES x WORD_WIDTH  per-bus send payload.
REQ-008 receiver_send_acks  out  TOTAL_BUSES  per-bus one-cycle acknowledge.
REQ-009 cfg_we  in  1  config write strobe.
REQ-010 cfg_bus  in  WORD_WIDTH  bus index addressed by config write.
REQ-011 cfg_enable  in  1  interrupt-enable bit written for cfg_bus.
REQ-012 cfg_addr  in  PROGRAM_ADDR_WIDTH  handler address written for cfg_bus.
REQ-013 wait_req  in  1  core blocked on a receive; selects wait mode.
REQ-014 wait_mask  in  TOTAL_BUSES  bus selection used in wait mode.
REQ-015 sel_valid  out  1  a send is offered to the core.
REQ-016 sel_ready  in  1  core accepts the offer.
REQ-017 sel_bus  out  WORD_WIDTH  index of offered bus.
REQ-018 sel_addr  out  PROGRAM_ADDR_WIDTH  handler address of offered bus (0 in wait mode).
REQ-019 sel_data  out  WORD_WIDTH  payload of offered bus.
REQ-020 sel_is_irq  out  1  offer is an interrupt (1) or a wait completion (0).
REQ-021 irq_done  in  1  core returned from interrupt handler.
REQ-022 irq_active  out  1  interrupt handler in progress.

Function
REQ-023 Masked request: wait_req=1 -> receiver_sends & wait_mask; wait_req=0 -> receiver_sends & enable table.
REQ-024 Arbitration round-robin: lowest index at or above rr_ptr wins, wrapping to index 0; rr_ptr width ceil(log2(TOTAL_BUSES)), minimum 1.
REQ-025 States IDLE, OFFER, ACK, BUSY; encoding free.
REQ-026 IDLE: any masked request -> OFFER next edge; latch bus, cfg address, data, sel_is_irq = ~wait_req; latency send-to-sel_valid 1 cycle.
REQ-027 IDLE in wait mode evaluates even when no interrupt is enabled; interrupts are never taken in BUSY (no nesting).
REQ-028 OFFER: sel_valid=1, outputs hold latched values, stable until accept or withdraw.
REQ-029 OFFER, sel_ready=1 -> ACK; rr_ptr <= latched bus + 1 mod TOTAL_BUSES.
REQ-030 OFFER, latched bus receiver_sends=0 and sel_ready=0 -> IDLE (withdraw), no ack, rr_ptr unchanged; sel_ready wins if both.
REQ-031 ACK: receiver_send_acks[latched bus]=1 for exactly one cycle; all other ack bits 0; sel_valid=0.
REQ-032 ACK -> BUSY if sel_is_irq=1, else IDLE.
REQ-033 BUSY: irq_active=1; irq_done=1 -> IDLE; irq_done outside BUSY ignored.
REQ-034 Config write: cfg_we=1 and cfg_bus < TOTAL_BUSES updates enable and address entries at edge; cfg_bus >= TOTAL_BUSES ignored.
REQ-035 Config write to the currently offered bus does not alter latched sel_addr; effective from next IDLE evaluation.
REQ-036 Config write and arbitration same cycle: IDLE evaluation uses pre-write table.
REQ-037 TOTAL_BUSES=1: rr_ptr constant 0.

Reset
REQ-038 reset low asynchronously forces IDLE, rr_ptr=0, enable table all 0, address table all 0, latched bus/addr/data 0.
REQ-039 During reset: sel_valid=0, sel_is_irq=0, irq_active=0, receiver_send_acks all 0, sel_bus/sel_addr/sel_data 0.
REQ-040 Reset mid-OFFER/ACK/BUSY discards the transaction; no ack issued after reset release.

Verification
REQ-041 TOTAL_BUSES=4; enable bus 2 addr 0x40; send[2]=1 data 0xDEADBEEF -> next cycle sel_valid=1, sel_bus=2, sel_addr=0x40, sel_is_irq=1; ready -> ack[2] one cycle, irq_active=1 until irq_done.
REQ-042 All enabled, sends 4'b1111 held, ready always 1, irq_done immediate -> grant order 0,1,2,3,0.
REQ-043 No enables, wait_req=1, wait_mask=4'b1000, send[3]=1 -> sel_is_irq=0, sel_addr=0, ack[3] then IDLE, irq_active stays 0.
REQ-044 Offer bus 1, drop send[1] before ready -> sel_valid falls next cycle, no ack, rr_ptr unchanged.
REQ-045 BUSY on bus 0, send[1] enabled -> no offer until irq_done; offer bus 1 one cycle after IDLE.
REQ-046 reset low during ACK -> all acks 0 immediately, state IDLE, enable table cleared.
